// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes, MIPS-subset opcode/funct constants
//                and the decoded issue-entry record passed from the decoder
//                to the issue stage.
//  Contents    : ALU_* control codes, OP_* opcodes, FUNCT_* R-type functs,
//                ISSUE_DATA_W operand width, issue_entry_t.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Operand width carried in an issue entry; alu_issue_stage.DATA_W must match.
   localparam int unsigned ISSUE_DATA_W = 32;

   // ALU control codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef struct packed {
      logic [3:0]              alu_ct;
      logic [ISSUE_DATA_W-1:0] src1;
      logic [ISSUE_DATA_W-1:0] src2;
      logic                    illegal;
   } issue_entry_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_stage_alu_ct_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ct_decode
//  Description : Purely combinational decode of a MIPS-subset instruction and
//                its register operands into an ALU issue entry.
//  Ports       : instr_i   - instruction word
//                rs_data_i - register rs value
//                rt_data_i - register rt value
//                entry_o   - decoded {alu_ct, src1, src2, illegal}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ct_decode
   import alu_pkg::*;
(
   input  logic [ISSUE_DATA_W-1:0] instr_i,
   input  logic [ISSUE_DATA_W-1:0] rs_data_i,
   input  logic [ISSUE_DATA_W-1:0] rt_data_i,
   output issue_entry_t            entry_o
);

   logic [5:0]              w_op;
   logic [5:0]              w_funct;
   logic [ISSUE_DATA_W-1:0] w_imm_sext;
   logic                    w_illegal;
   logic [3:0]              w_ct;
   logic [ISSUE_DATA_W-1:0] w_src2;

   // Register-number fields are resolved upstream by the register file.
   logic w_unused_fields;
   assign w_unused_fields = ^instr_i[25:16];

   assign w_op       = instr_i[31:26];
   assign w_funct    = instr_i[5:0];
   assign w_imm_sext = {{(ISSUE_DATA_W-16){instr_i[15]}}, instr_i[15:0]};

   always_comb begin
      w_illegal = 1'b0;
      w_ct      = ALU_AND;
      w_src2    = rt_data_i;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               FUNCT_ADD: w_ct = ALU_ADD;
               FUNCT_SUB: w_ct = ALU_SUB;
               FUNCT_AND: w_ct = ALU_AND;
               FUNCT_OR:  w_ct = ALU_OR;
               FUNCT_SLT: w_ct = ALU_SLT;
               default:   w_illegal = 1'b1;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI: begin
            w_ct   = ALU_ADD;
            w_src2 = w_imm_sext;
         end
         OP_BEQ:  w_ct = ALU_SUB;
         default: w_illegal = 1'b1;
      endcase
   end

   // Illegal entries carry all-zero operands so nothing stale reaches the ALU.
   always_comb begin
      entry_o.illegal = w_illegal;
      entry_o.alu_ct  = w_illegal ? ALU_AND : w_ct;
      entry_o.src1    = w_illegal ? '0 : rs_data_i;
      entry_o.src2    = w_illegal ? '0 : w_src2;
   end

endmodule : alu_ct_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : ID/EX-style issue register for the ALU. Decodes the accepted
//                instruction, holds it behind a valid/ready handshake with a
//                2-entry skid buffer, supports flush, and counts illegal
//                instructions (saturating).
//  Ports       : clk, rst (async, active-high), flush_i
//                in_valid_i / in_ready_o        - upstream handshake
//                instr_i, rs_data_i, rt_data_i  - instruction and operands
//                out_valid_o / out_ready_i      - downstream handshake
//                alu_ct_o, alu_src1_o, alu_src2_o, illegal_o - output entry
//                illegal_cnt_o                  - saturating illegal count
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,   // must equal alu_pkg::ISSUE_DATA_W
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [3:0]        alu_ct_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  illegal_cnt_o
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   issue_entry_t     main_q, main_d;
   issue_entry_t     skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   issue_entry_t     w_dec;
   logic             w_in_xfer;
   logic             w_out_xfer;

   alu_ct_decode u_decode (
      .instr_i   (instr_i),
      .rs_data_i (rs_data_i),
      .rt_data_i (rt_data_i),
      .entry_o   (w_dec)
   );

   assign w_in_xfer  = in_valid_i && in_ready_q;
   assign w_out_xfer = out_valid_q && out_ready_i;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (w_in_xfer) state_d = ST_ONE;
         ST_ONE: begin
            if (w_in_xfer && !w_out_xfer)      state_d = ST_FULL;
            else if (!w_in_xfer && w_out_xfer) state_d = ST_EMPTY;
         end
         ST_FULL:  if (w_out_xfer) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush_i) state_d = ST_EMPTY;
   end

   // ------------------------------------------------------ datapath / outputs
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      case (state_q)
         ST_EMPTY: if (w_in_xfer) main_d = w_dec;
         ST_ONE: begin
            // Entry arriving while main is still held parks in skid.
            if (w_in_xfer && w_out_xfer) main_d = w_dec;
            else if (w_in_xfer)          skid_d = w_dec;
         end
         ST_FULL:  if (w_out_xfer) main_d = skid_q;
         default: ;
      endcase

      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);

      // Counted on acceptance, so a simultaneous flush does not hide it.
      cnt_d = cnt_q;
      if (w_in_xfer && w_dec.illegal && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_ONE;
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign alu_ct_o      = main_q.alu_ct;
   assign alu_src1_o    = main_q.src1;
   assign alu_src2_o    = main_q.src2;
   assign illegal_o     = main_q.illegal;
   assign illegal_cnt_o = cnt_q;

endmodule : alu_issue_stage
`default_nettype wire
